// File: rtl/logic_op_pkg.sv
// Shared opcode encodings and FSM state type for the logic-op arbiter.
package logic_op_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational WIDTH-bit bitwise logic unit; reserved opcode yields zero and flags err.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_err
);

    always_comb begin
        o_y   = '0;
        o_err = 1'b0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_NOT:  o_y = ~i_a;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XOR:  o_y = i_a ^ i_b;
            OP_XNOR: o_y = ~(i_a ^ i_b);
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit among NUM_REQ requesters,
// with a single registered, ID-tagged response channel.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [IDW-1:0]             rsp_id,
    output logic                       rsp_err,
    output logic                       busy
);

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [WIDTH-1:0]   r_data;
    logic [IDW-1:0]     r_id;
    logic               r_err;

    logic               w_acc;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0]     w_gidx;
    logic [OP_W-1:0]    w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_y;
    logic               w_err;

    // One-hot pick of the first valid index scanning circularly from ptr+1.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                   input logic [IDW-1:0] ptr);
        int idx;
        rr_pick = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (rr_pick == '0 && v[idx])
                rr_pick[idx] = 1'b1;
        end
    endfunction

    // rst_n gating keeps req_ready low throughout reset even though IDLE accepts.
    assign w_acc     = rst_n & ((r_state == ST_IDLE) | rsp_ready);
    assign w_gnt     = rr_pick(req_valid, r_ptr);
    assign req_ready = w_acc ? w_gnt : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_gidx = '0;
        w_op   = '0;
        w_a    = '0;
        w_b    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_gidx = IDW'(k);
                w_op   = req_op[k*OP_W +: OP_W];
                w_a    = req_a[k*WIDTH +: WIDTH];
                w_b    = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    logic_unit #(.WIDTH(WIDTH)) u_lu (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_y   (w_y),
        .o_err (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= IDW'(NUM_REQ - 1);
            r_data  <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (w_xfer) begin
            r_state <= ST_RESP;
            r_ptr   <= w_gidx;
            r_data  <= w_y;
            r_id    <= w_gidx;
            r_err   <= w_err;
        end else if (r_state == ST_RESP && rsp_ready) begin
            r_state <= ST_IDLE;
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state == ST_RESP);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: inputs change on the falling edge, outputs are checked there.
module tb_logic_op_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*3-1:0] req_op;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_y [0:7];
    logic [NR-1:0] exp_rdy;

    logic_op_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 3'd1, 8'(i), 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rsp_data); end
        checks++; if (rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_id_err got %0d/%b exp 0/0", rsp_id, rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
        req_valid = 4'h0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_xfer got %b exp 0", rsp_valid); end
    endtask

    task automatic test_single();
        set_req(1, 3'd0, 8'hF0, 8'h3C);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_valid got %b/%b exp 1/1", rsp_valid, busy); end
        checks++; if (rsp_data !== 8'h30) begin errors++; $display("FAIL single_data got %h exp 30", rsp_data); end
        checks++; if (rsp_id !== 2'd1 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err got %0d/%b exp 1/0", rsp_id, rsp_err); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drop got %b/%b exp 0/0", rsp_valid, busy); end
        checks++; if (rsp_data !== 8'h30 || rsp_id !== 2'd1) begin errors++; $display("FAIL single_hold got %h/%0d exp 30/1", rsp_data, rsp_id); end
    endtask

    task automatic test_op_sweep();
        exp_y = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 3'(k), 8'hA5, 8'h0F);
            req_valid = 4'b0001;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sweep_ready op %0d got %b exp 0001", k, req_ready); end
            @(negedge clk);
            req_valid = 4'b0000;
            checks++; if (rsp_data !== exp_y[k] || rsp_valid !== 1'b1) begin errors++; $display("FAIL sweep_data op %0d got %h/%b exp %h/1", k, rsp_data, rsp_valid, exp_y[k]); end
            checks++; if (rsp_err !== (k == 7)) begin errors++; $display("FAIL sweep_err op %0d got %b exp %b", k, rsp_err, (k == 7)); end
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 3'd1, 8'(i + 1), 8'h00);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL contention_id step %0d got %b/%0d exp 1/%0d", k, rsp_valid, rsp_id, k % 4); end
            checks++; if (rsp_data !== 8'((k % 4) + 1)) begin errors++; $display("FAIL contention_data step %0d got %h exp %h", k, rsp_data, 8'((k % 4) + 1)); end
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready step %0d got %b exp %b", k, req_ready, exp_rdy); end
        end
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        set_req(2, 3'd0, 8'hFF, 8'h12);
        set_req(3, 3'd1, 8'h00, 8'h34);
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h12 || rsp_id !== 2'd2) begin errors++; $display("FAIL bp_hold cyc %0d got %b/%h/%0d exp 1/12/2", c, rsp_valid, rsp_data, rsp_id); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h34) begin errors++; $display("FAIL bp_next got %b/%0d/%h exp 1/3/34", rsp_valid, rsp_id, rsp_data); end
    endtask

    task automatic test_reset_mid_op();
        set_req(1, 3'd5, 8'h3C, 8'hFF);
        set_req(2, 3'd0, 8'hFF, 8'h77);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL mid_held got %b/%0d exp 1/3", rsp_valid, rsp_id); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset got %b/%b/%b exp 0/0/0000", rsp_valid, busy, req_ready); end
        checks++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_reset_data got %h/%0d exp 00/0", rsp_data, rsp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hC3) begin errors++; $display("FAIL mid_resp got %b/%0d/%h exp 1/1/c3", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay got %b exp 0", rsp_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_op_sweep();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit between NUM_REQ requesters.
- The unit supports AND, OR, NOT, NAND, NOR, XOR and XNOR.
- Arbitration is round-robin with a valid/ready handshake on each request port, and results are registered onto a single response channel tagged with the requester ID.
- The block sits between the control clients and the gate datapath, and is the only path by which clients reach the logic unit.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ*3  per-requester opcode; requester i occupies bits [3i+2:3i].
- req_a  in  NUM_REQ*WIDTH  per-requester operand A; requester i occupies slice i.
- req_b  in  NUM_REQ*WIDTH  per-requester operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_data  out  WIDTH  result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that is being answered.
- rsp_err  out  1  the opcode was reserved.
- busy  out  1  high whenever a response is held.

Behaviour:
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 NOT (~a; b ignored)
  - 3 NAND
  - 4 NOR
  - 5 XOR
  - 6 XNOR
  - 7 reserved: result 0, rsp_err=1.
- All operations are bitwise over WIDTH bits. No arithmetic and no width growth.
- States:
  - IDLE: no held response.
  - RESP: a response is held with rsp_valid=1.
- Accept condition: acc = (state==IDLE) | (state==RESP & rsp_ready).
- Grant:
  - When acc=1 and any req_valid=1, grant the first valid index scanning upward (circularly) from ptr+1.
  - req_ready[g] = 1 combinationally, in the same cycle.
  - All other req_ready bits are 0.
  - When acc=0, req_ready = 0.
- Transfer:
  - A transfer occurs on req_valid[g] & req_ready[g].
  - On the next edge: rsp_data/rsp_err hold the logic unit output for requester g's op/a/b, rsp_id=g, ptr=g, state=RESP.
  - Latency from transfer to rsp_valid is 1 cycle.
- Response completion: in RESP, if rsp_ready=1 and no req_valid, go to IDLE. rsp_valid drops on the next edge and rsp_data/rsp_id/rsp_err keep their last values.
- Back-to-back: in RESP, if rsp_ready=1 and some req_valid, the new grant occurs in the same cycle. The block stays in RESP with new data, giving a throughput of 1 op/cycle.
- Backpressure: in RESP with rsp_ready=0, all outputs hold stable and req_ready=0.
- Requester rules: requesters hold valid/op/a/b stable until ready. Dropping valid without ready is legal and causes no grant.
- Fairness: a continuously-valid requester is granted within NUM_REQ grants.
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - ptr=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while rst_n is low.
- Reset mid-operation: a held response is discarded and never re-presented.
- busy = (state==RESP).

Decomposition:
- Package logic_op_pkg: opcode localparams (OP_AND..OP_XNOR, OP_RSVD=7) and OP_W=3.
- Sub-module logic_unit: purely combinational; inputs op, a, b; outputs y, err. It is instantiated once in logic_op_arbiter.
- The round-robin pick is an in-module function.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0x00, busy=0. After release, the first grant goes to requester 0.
- Single request: req 1, op=0, a=0xF0, b=0x3C, rsp_ready=1 -> req_ready=4'b0010 in cycle 0. Next cycle rsp_valid=1, rsp_data=0x30, rsp_id=1, rsp_err=0. The cycle after, rsp_valid=0.
- Op sweep: a=0xA5, b=0x0F on req 0, ops 0..7 in turn -> results 0x05, 0xAF, 0x5A, 0xFA, 0x50, 0xAA, 0x55. Op 7 gives 0x00 with rsp_err=1.
- Contention: all 4 req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, rsp_valid continuously 1.
- Backpressure: rsp_ready=0 for 5 cycles while reqs 2 and 3 are valid -> rsp_valid, rsp_data and rsp_id stay stable and req_ready=0. On release, the next response is rsp_id=3 if the held response was from req 2.
- Reset mid-operation: pulse rst_n low for 1 cycle while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately. The held result is never re-presented, and the next grant goes to the lowest valid index.
